// File: rtl/vga_scene_pkg.sv
// Shared types for the VGA scene scheduler: FSM states, the flattened VGA stream
// bundle carried between draw pipelines, and the scene-select width helper.
package vga_scene_pkg;

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } scene_state_t;

  localparam logic [11:0] BLACK_RGB = 12'h000;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_sig_t;

  // A single source still needs a 1-bit select so ports never collapse to zero width.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Frame reference: one-cycle pulse on the rising edge of the reference vblnk.
module vga_frame_edge (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_start
);

  logic vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk;
  end

  assign frame_start = vblnk & ~vblnk_q;

endmodule

// File: rtl/vga_scene_sched.sv
// Frame-synchronous scene scheduler: switches the shared VGA stream between
// cycle-aligned draw pipelines only at frame boundaries, with optional black frames.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   SHOW    | cur_scene drives the output, requests accepted
//   PENDING | new scene latched, old scene finishes its frame
//   BLANK   | new scene timing selected, rgb forced black for whole frames
module vga_scene_sched
  import vga_scene_pkg::*;
#(
  parameter  int N_SRC        = 4,
  parameter  int BLANK_FRAMES = 1,
  parameter  int RESET_SCENE  = 0,
  localparam int SEL_W        = sel_width(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  vga_sig_t [N_SRC-1:0]    src_in,
  output vga_sig_t                vga_out,
  input  logic [SEL_W-1:0]        req_scene,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [SEL_W-1:0]        cur_scene,
  output logic                    busy,
  output logic                    req_err
);

  localparam logic [3:0] BLANK_LOAD = (BLANK_FRAMES == 0) ? 4'd0 : 4'(BLANK_FRAMES - 1);
  localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_SCENE);

  scene_state_t     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             frame_start;
  logic             xfer;
  logic             req_oor;
  vga_sig_t         src_sel;

  // All sources share timing, so source 0 is the frame reference.
  vga_frame_edge u_frame_edge (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (src_in[0].vblnk),
    .frame_start (frame_start)
  );

  assign req_ready = !rst && (state_q == SHOW);
  assign xfer      = req_valid && req_ready;
  assign req_oor   = int'(req_scene) >= N_SRC;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      SHOW: begin
        // A frame_start in this cycle is deliberately ignored: the old scene
        // always gets one more full frame after the request is latched.
        if (xfer) begin
          if (req_oor) begin
            err_d = 1'b1;
          end else if (req_scene != cur_q) begin
            pend_d  = req_scene;
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (frame_start) begin
          sel_d = pend_q;
          if (BLANK_FRAMES == 0) begin
            cur_d   = pend_q;
            state_d = SHOW;
          end else begin
            cnt_d   = BLANK_LOAD;
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (frame_start) begin
          if (cnt_q == 4'd0) begin
            cur_d   = pend_q;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = SHOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      sel_q   <= RESET_SEL;
      cur_q   <= RESET_SEL;
      pend_q  <= RESET_SEL;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign src_sel = src_in[sel_q];

  // Timing fields always pass through; only colour is suppressed while blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out <= '0;
    end else begin
      vga_out <= src_sel;
      if ((state_q == BLANK) || src_sel.hblnk || src_sel.vblnk)
        vga_out.rgb <= BLACK_RGB;
    end
  end

  assign cur_scene = cur_q;
  assign busy      = (state_q != SHOW);
  assign req_err   = err_q;

endmodule

// File: tb/tb_vga_scene_sched.sv
// Scoreboard bench for vga_scene_sched: a driver pushes the expected vga_out word
// for every pixel it applies, and a monitor pops and compares one clock later.
module tb_vga_scene_sched;
  import vga_scene_pkg::*;

  localparam int N_SRC        = 5;
  localparam int BLANK_FRAMES = 1;
  localparam int RESET_SCENE  = 0;
  localparam int SEL_W        = sel_width(N_SRC);
  localparam int H_TOT = 16, H_ACT = 10, V_TOT = 8, V_ACT = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  vga_sig_t [N_SRC-1:0] src_in;
  vga_sig_t             vga_out;
  logic [SEL_W-1:0]     req_scene = '0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [SEL_W-1:0]     cur_scene;
  logic                 busy;
  logic                 req_err;

  vga_scene_sched #(
    .N_SRC        (N_SRC),
    .BLANK_FRAMES (BLANK_FRAMES),
    .RESET_SCENE  (RESET_SCENE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .vga_out   (vga_out),
    .req_scene (req_scene),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cur_scene (cur_scene),
    .busy      (busy),
    .req_err   (req_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0] scene;
    logic             black;
  } plan_t;

  int               vectors = 0;
  int               miscompares = 0;
  vga_sig_t         exp_q[$];
  plan_t            plan_q[$];
  int               hc = 0;
  int               vc = 0;
  logic [SEL_W-1:0] exp_scene = '0;
  logic             exp_black = 1'b0;

  function automatic vga_sig_t mk_src(input int s, input int h, input int v);
    vga_sig_t r;
    r.hcount = 11'(h);
    r.vcount = 11'(v);
    r.hblnk  = (h >= H_ACT);
    r.hsync  = (h == 12) || (h == 13);
    r.vblnk  = (v >= V_ACT);
    r.vsync  = (v == 6);
    r.rgb    = {4'(s + 1), 4'(h), 4'(v)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One pixel: drive sources, queue the expected output, advance the raster.
  // Plan entries describe the period that starts after each frame boundary.
  task automatic step();
    vga_sig_t e;
    for (int s = 0; s < N_SRC; s++) src_in[s] = mk_src(s, hc, vc);
    e = mk_src(int'(exp_scene), hc, vc);
    if (exp_black || e.hblnk || e.vblnk) e.rgb = 12'h000;
    if (rst) e = '0;
    exp_q.push_back(e);
    if (hc == 0 && vc == V_ACT && plan_q.size() > 0) {exp_scene, exp_black} = plan_q.pop_front();
    @(posedge clk);
    hc = (hc == H_TOT - 1) ? 0 : hc + 1;
    if (hc == 0) vc = (vc == V_TOT - 1) ? 0 : vc + 1;
    @(negedge clk);
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(hc == h && vc == v)) begin
      if (n == 256) begin
        miscompares++;
        $display("FAIL goto_timeout: stuck at h=%0d v=%0d target h=%0d v=%0d", hc, vc, h, v);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic request(input int s);
    req_scene = SEL_W'(s);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin : monitor
    vga_sig_t e;
    forever begin
      @(posedge clk);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got %h expected queued entry", vga_out);
      end else begin
        e = exp_q.pop_front();
        if (vga_out !== e) begin
          miscompares++;
          $display("FAIL vga_out @%0t: got %h expected %h", $time, vga_out, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin : script
    rst = 1'b1;
    repeat (3) step();
    chk("rst_cur_scene", 32'(cur_scene), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_req_err", 32'(req_err), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 1);

    // Switch 0 -> 2 mid-frame: finish src0 frame, one black frame, then src2.
    goto(3, 2);
    plan_q.push_back('{scene: SEL_W'(2), black: 1'b1});
    plan_q.push_back('{scene: SEL_W'(2), black: 1'b0});
    request(2);
    chk("a_busy_pending", 32'(busy), 1);
    chk("a_cur_pending", 32'(cur_scene), 0);
    chk("a_ready_pending", 32'(req_ready), 0);
    goto(0, 5);
    step();
    goto(4, 1);
    chk("a_busy_blank", 32'(busy), 1);
    chk("a_cur_blank", 32'(cur_scene), 0);
    goto(0, 5);
    step();
    chk("a_busy_done", 32'(busy), 0);
    chk("a_cur_done", 32'(cur_scene), 2);

    // Same-scene request: accepted, nothing changes.
    goto(5, 1);
    request(2);
    chk("b_busy", 32'(busy), 0);
    chk("b_cur", 32'(cur_scene), 2);
    chk("b_req_err", 32'(req_err), 0);
    goto(0, 5);
    step();
    goto(4, 1);
    chk("b_busy_next_frame", 32'(busy), 0);

    // Out-of-range requests: one-cycle error pulse, scene kept.
    request(5);
    chk("c5_req_err", 32'(req_err), 1);
    chk("c5_busy", 32'(busy), 0);
    step();
    chk("c5_req_err_clear", 32'(req_err), 0);
    request(7);
    chk("c7_req_err", 32'(req_err), 1);
    step();
    chk("c7_req_err_clear", 32'(req_err), 0);
    chk("c_cur", 32'(cur_scene), 2);

    // Request on the frame_start cycle: old scene runs one more full frame.
    goto(0, 5);
    plan_q.push_back('{scene: SEL_W'(2), black: 1'b0});
    plan_q.push_back('{scene: SEL_W'(1), black: 1'b1});
    plan_q.push_back('{scene: SEL_W'(1), black: 1'b0});
    request(1);
    chk("d_busy_pending", 32'(busy), 1);
    chk("d_cur_pending", 32'(cur_scene), 2);
    goto(0, 5);
    step();
    goto(2, 1);
    chk("d_busy_blank", 32'(busy), 1);
    req_scene = SEL_W'(3);
    req_valid = 1'b1;
    #1;
    chk("d_ready_blank", 32'(req_ready), 0);
    repeat (20) step();
    req_valid = 1'b0;
    goto(0, 5);
    step();
    chk("d_busy_done", 32'(busy), 0);
    chk("d_cur_done", 32'(cur_scene), 1);
    goto(0, 5);
    step();
    goto(2, 2);
    chk("d_cur_stable", 32'(cur_scene), 1);
    chk("d_busy_stable", 32'(busy), 0);

    // Reset while blanking aborts the change and returns to scene 0.
    goto(3, 2);
    plan_q.push_back('{scene: SEL_W'(3), black: 1'b1});
    plan_q.push_back('{scene: SEL_W'(3), black: 1'b0});
    request(3);
    goto(0, 5);
    step();
    goto(4, 1);
    chk("e_busy_blank", 32'(busy), 1);
    rst = 1'b1;
    plan_q.delete();
    exp_scene = SEL_W'(RESET_SCENE);
    exp_black = 1'b0;
    step();
    chk("e_busy_rst", 32'(busy), 0);
    chk("e_cur_rst", 32'(cur_scene), RESET_SCENE);
    chk("e_ready_rst", 32'(req_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("e_ready_after", 32'(req_ready), 1);
    goto(0, 5);
    step();
    goto(5, 2);
    chk("e_cur_after", 32'(cur_scene), RESET_SCENE);
    chk("e_busy_after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
